// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue/sequencing front-end for the RV32M multiplier.
// Accepts one multiply request, holds the operands for MUL_LATENCY cycles,
// captures the unsigned 64-bit product and turns it into the 32-bit result
// for mul/mulh/mulhsu/mulhu.
// Optional build macro: MUL_ZERO_FAST_EN (zero-operand requests skip the wait).
//
// Handshake: a request transfers on a posedge with req_valid & req_ready;
// a response transfers on a posedge with rsp_valid & rsp_ready. Once raised,
// rsp_valid and rsp_data stay stable until the transfer, a flush or a reset.
`timescale 1ns/1ps
module mul_issue_ctrl #(
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic        flush,
    output logic [31:0] mul_rs1,
    output logic [31:0] mul_rs2,
    output logic [2:0]  mul_funct3,
    input  logic [63:0] mul_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(MUL_LATENCY);

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  f3_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic [31:0] result_d;
    logic        zero_op;

`ifdef MUL_ZERO_FAST_EN
    assign zero_op = (req_rs1 == 32'd0) || (req_rs2 == 32'd0);
`else
    assign zero_op = 1'b0;
`endif

    // The multiplier always runs unsigned; signed corrections are applied here.
    assign mul_funct3 = 3'b000;
    assign mul_rs1    = a_q;
    assign mul_rs2    = b_q;
    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign dbg_state  = state_q;

    // Result select: high word of the unsigned product minus the signed corrections.
    always_comb begin
        logic [31:0] hi;
        logic [31:0] corr_a;
        logic [31:0] corr_b;
        hi     = mul_out[63:32];
        corr_a = a_q[31] ? b_q : 32'd0;
        corr_b = b_q[31] ? a_q : 32'd0;
        result_d = 32'd0;
        case (f3_q)
            3'b000:  result_d = mul_out[31:0];
            3'b001:  result_d = hi - corr_a - corr_b;
            3'b010:  result_d = hi - corr_a;
            3'b011:  result_d = hi;
            default: result_d = 32'd0;
        endcase
    end

    // Control FSM with registered handshake outputs and operand/result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            f3_q        <= 3'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
        end else if (flush) begin
            // Flush wins over any accept or response transfer this cycle.
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        a_q         <= req_rs1;
                        b_q         <= req_rs2;
                        f3_q        <= req_funct3;
                        req_ready_q <= 1'b0;
                        if (zero_op) begin
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= 32'd0;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= LAT_INIT;
                        end
                    end
                end
                WAIT: begin
                    // Counter runs MUL_LATENCY..0 so capture lands MUL_LATENCY+1 cycles after accept.
                    if (cnt_q == 3'd0) begin
                        rsp_data_q  <= result_d;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Testbench for mul_issue_ctrl: pipelined multiplier model, directed cases,
// randomized traffic with response backpressure, scoreboard monitor.
`timescale 1ns/1ps
module tb_mul_issue_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        flush;
    logic [31:0] mul_rs1;
    logic [31:0] mul_rs2;
    logic [2:0]  mul_funct3;
    logic [63:0] mul_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int xfer_cnt = 0;
    bit rnd_bp   = 1'b0;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    mul_issue_ctrl #(.MUL_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .flush(flush),
        .mul_rs1(mul_rs1), .mul_rs2(mul_rs2), .mul_funct3(mul_funct3),
        .mul_out(mul_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .dbg_state(dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Unsigned multiplier model: product of the presented operands appears LAT cycles later
    logic [63:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= {32'd0, mul_rs1} * {32'd0, mul_rs2};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_out = pipe[LAT-1];

    // Random response backpressure
    always @(posedge clk) begin
        if (rnd_bp) begin
            #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference result from signed/unsigned 64-bit arithmetic
    function automatic logic [31:0] ref_data(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int lat_of(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_ZERO_FAST_EN
        if (a == 32'd0 || b == 32'd0) return 1;
`endif
        return LAT + 1;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard monitor: samples on the falling edge, before the next active edge
    logic        prev_v = 1'b0;
    logic [31:0] held   = 32'd0;
    int          rise_cyc = 0;
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (!prev_v) rise_cyc = cyc;
            else chk("rsp_hold", rsp_data, held);
            if (rsp_ready === 1'b1 && flush !== 1'b1 && rst !== 1'b1) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    chk("rsp_data", rsp_data, exp_q.pop_front());
                    chk("rsp_latency", rise_cyc, lat_q.pop_front());
                    chk("mul_funct3", mul_funct3, 3'b000);
                end
            end
        end
        prev_v = (rsp_valid === 1'b1);
        held   = rsp_data;
    end

    // Driver: present a request, wait for acceptance, push the expectation
    task automatic do_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit push);
        int n = 0;
        req_funct3 = f3;
        req_rs1    = a;
        req_rs2    = b;
        req_valid  = 1'b1;
        while (req_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (req_ready !== 1'b1) begin
            chk("req_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (push) begin
            exp_q.push_back(exp);
            lat_q.push_back(cyc + lat_of(a, b));
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (rsp_valid !== 1'b1) chk("valid_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid === 1'b1) && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        if (exp_q.size() != 0 || rsp_valid === 1'b1) chk("drain_timeout", 0, 1);
    endtask

    task automatic idle_cycles(input string name, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        chk(name, seen, 1'b0);
    endtask

    initial begin
        logic [31:0] a, b, hold_v;
        logic [2:0]  f3;
        int          x0;

        rst = 1'b1; req_valid = 1'b0; req_funct3 = 3'd0; req_rs1 = 32'd0; req_rs2 = 32'd0;
        flush = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_mul_rs1", mul_rs1, 32'd0);
        chk("rst_mul_rs2", mul_rs2, 32'd0);
        chk("rst_mul_funct3", mul_funct3, 3'b000);

        // Directed results
        do_req(3'd0, 32'd7, 32'd6, 32'h0000_002A, 1'b1);
        drain();
        chk("ready_after_rsp", req_ready, 1'b1);
        do_req(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        do_req(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
        do_req(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b1);
        do_req(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        do_req(3'd0, 32'd0, 32'h1234_5678, 32'd0, 1'b1);
        drain();

        // Response backpressure with ignored requests
        rsp_ready = 1'b0;
        a = $urandom; b = $urandom;
        do_req(3'd3, a, b, ref_data(3'd3, a, b), 1'b1);
        wait_valid();
        hold_v = rsp_data;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_funct3 = 3'd0; req_rs1 = $urandom; req_rs2 = $urandom;
            @(posedge clk); #1;
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_data", rsp_data, hold_v);
            chk("bp_req_ready", req_ready, 1'b0);
        end
        req_valid = 1'b0;
        x0 = xfer_cnt;
        rsp_ready = 1'b1;
        drain();
        chk("bp_single_xfer", xfer_cnt - x0, 1);
        chk("bp_back_idle", req_ready, 1'b1);
        idle_cycles("bp_ignored_req", 6);

        // Flush in WAIT with a competing request
        req_funct3 = 3'd0; req_rs1 = 32'd5; req_rs2 = 32'd9; req_valid = 1'b1;
        @(posedge clk); #1;
        chk("flush_accepted", req_ready, 1'b0);
        flush = 1'b1; req_rs1 = 32'd11; req_rs2 = 32'd13;
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        chk("flush_idle", req_ready, 1'b1);
        chk("flush_no_valid", rsp_valid, 1'b0);
        idle_cycles("flush_no_rsp", 6);

        // Reset while holding a response
        rsp_ready = 1'b0;
        do_req(3'd0, 32'd3, 32'd4, 32'd12, 1'b0);
        wait_valid();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_done_valid", rsp_valid, 1'b0);
        chk("rst_done_mul_rs1", mul_rs1, 32'd0);
        chk("rst_done_mul_rs2", mul_rs2, 32'd0);
        chk("rst_done_ready", req_ready, 1'b1);
        rsp_ready = 1'b1;

        // Randomized traffic with random backpressure
        rnd_bp = 1'b1;
        for (int i = 0; i < 200; i++) begin
            f3 = 3'($urandom_range(0, 3));
            a  = rnd_op();
            b  = rnd_op();
            do_req(f3, a, b, ref_data(f3, a, b), 1'b1);
        end
        drain();
        rnd_bp = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
